// File: rtl/result_bcd_converter.sv
// Sequential binary-to-BCD converter for the calculator output stage.
// Resolves the sign of subtraction results, then runs an iterative shift-add-3 conversion.
module result_bcd_converter #(
  parameter int DATA_WIDTH = 18,
  parameter int DIGITS     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              operation,
  input  logic [DATA_WIDTH-1:0]   result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*DIGITS-1:0]     bcd,
  output logic                    negative
);

  localparam int                     BCD_W      = 4 * DIGITS;
  localparam int                     CNT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0]       CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0]       CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]       LAST_COUNT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0]  DATA_ZERO  = DATA_WIDTH'(0);
  localparam logic [DATA_WIDTH-1:0]  DATA_ONE   = DATA_WIDTH'(1);
  localparam logic [BCD_W-1:0]       BCD_ZERO   = BCD_W'(0);
  localparam logic [1:0]             OP_SUB     = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  state_e                  state_r;
  state_e                  state_s;
  logic                    accept_s;
  logic                    last_shift_s;

  logic [CNT_W-1:0]        count_r;
  logic [DATA_WIDTH-1:0]   mag_r;
  logic [BCD_W-1:0]        scratch_r;
  logic                    neg_pend_r;

  logic                    neg_in_s;
  logic [DATA_WIDTH-1:0]   mag_in_s;
  logic [BCD_W-1:0]        scratch_adj_s;
  logic [BCD_W-1:0]        scratch_shift_s;
  logic [DATA_WIDTH-1:0]   mag_shift_s;

  logic                    in_ready_r;
  logic                    out_valid_r;
  logic [BCD_W-1:0]        bcd_r;
  logic                    negative_r;

  // Add 3 to every digit that is 5 or more so the following doubling carries into the next decade.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] digits);
    logic [BCD_W-1:0] adj;
    logic [3:0]       d;
    adj = BCD_ZERO;
    for (int i = 0; i < DIGITS; i++) begin
      d = digits[4*i +: 4];
      if (d >= 4'd5) begin
        adj[4*i +: 4] = d + 4'd3;
      end else begin
        adj[4*i +: 4] = d;
      end
    end
    return adj;
  endfunction

  // Sign resolution: only subtraction results are treated as two's complement.
  always_comb begin
    neg_in_s = (operation == OP_SUB) && result[DATA_WIDTH-1];
    if (neg_in_s) begin
      mag_in_s = ~result + DATA_ONE;
    end else begin
      mag_in_s = result;
    end
  end

  // One double-dabble step on {scratch, magnitude}.
  always_comb begin
    scratch_adj_s   = add3_digits(scratch_r);
    scratch_shift_s = {scratch_adj_s[BCD_W-2:0], mag_r[DATA_WIDTH-1]};
    mag_shift_s     = {mag_r[DATA_WIDTH-2:0], 1'b0};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode and handshake events.
  always_comb begin
    state_s      = state_r;
    accept_s     = 1'b0;
    last_shift_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_s  = ST_SHIFT;
          accept_s = 1'b1;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (count_r == LAST_COUNT) begin
          state_s      = ST_DONE;
          last_shift_s = 1'b1;
        end else begin
          state_s      = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Conversion datapath: latch on accept, shift once per SHIFT cycle, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r    <= CNT_ZERO;
      mag_r      <= DATA_ZERO;
      scratch_r  <= BCD_ZERO;
      neg_pend_r <= 1'b0;
    end else if (accept_s) begin
      count_r    <= CNT_ZERO;
      mag_r      <= mag_in_s;
      scratch_r  <= BCD_ZERO;
      neg_pend_r <= neg_in_s;
    end else if (state_r == ST_SHIFT) begin
      count_r    <= count_r + CNT_ONE;
      mag_r      <= mag_shift_s;
      scratch_r  <= scratch_shift_s;
    end else begin
      count_r    <= count_r;
      mag_r      <= mag_r;
      scratch_r  <= scratch_r;
      neg_pend_r <= neg_pend_r;
    end
  end

  // Registered outputs; flags follow the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      bcd_r       <= BCD_ZERO;
      negative_r  <= 1'b0;
    end else begin
      in_ready_r  <= (state_s == ST_IDLE);
      out_valid_r <= (state_s == ST_DONE);
      if (last_shift_s) begin
        bcd_r      <= scratch_shift_s;
        negative_r <= neg_pend_r;
      end else begin
        bcd_r      <= bcd_r;
        negative_r <= negative_r;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign bcd       = bcd_r;
  assign negative  = negative_r;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Scoreboard bench for result_bcd_converter: driver pushes reference-model results on accept,
// a negedge monitor compares whenever the converter presents an output.
module tb_result_bcd_converter;

  localparam int DW = 18;
  localparam int DG = 6;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    operation;
  logic [DW-1:0] result;
  logic          out_valid;
  logic          out_ready;
  logic [4*DG-1:0] bcd;
  logic          negative;

  typedef struct {
    logic [4*DG-1:0] bcd;
    logic            neg;
    int              acc;
  } exp_t;

  exp_t sb[$];

  int total_cnt = 0;
  int pass_cnt  = 0;
  int cyc       = 0;
  int last_xfer = -1;
  bit spacing_en = 1'b0;
  bit bp_mode    = 1'b0;
  bit prev_ov    = 1'b0;
  bit prev_xfer  = 1'b0;
  logic [4*DG-1:0] last_bcd = '0;
  logic            last_neg = 1'b0;

  result_bcd_converter #(.DATA_WIDTH(DW), .DIGITS(DG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd),
    .negative  (negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: signed interpretation for sub only, then decimal digits by division.
  function automatic exp_t model(input logic [1:0] op, input logic [DW-1:0] res);
    exp_t e;
    int unsigned m;
    e.neg = (op == 2'b01) && res[DW-1];
    m = e.neg ? ((32'd1 << DW) - 32'(res)) : 32'(res);
    e.bcd = '0;
    for (int i = 0; i < DG; i++) begin
      e.bcd[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    e.acc = 0;
    return e;
  endfunction

  task automatic send(input logic [1:0] op, input logic [DW-1:0] res, input bit push,
                      input bit hold, output int acc);
    int t;
    exp_t e;
    operation = op;
    result    = res;
    in_valid  = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      total_cnt++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
      acc = -1;
      @(posedge clk);
      #1 in_valid = 1'b0;
    end else begin
      acc = cyc + 1;
      @(posedge clk);
      if (push) begin
        e = model(op, res);
        e.acc = acc;
        sb.push_back(e);
      end
      #1;
      if (!hold) in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      total_cnt++;
      $display("FAIL drain_timeout: pending got %0d expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares presented outputs against the scoreboard head and checks hold behaviour.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ov   = 1'b0;
        prev_xfer = 1'b0;
        last_bcd  = '0;
        last_neg  = 1'b0;
      end else begin
        if (prev_xfer) begin
          check("pulse_width", 32'(out_valid), 32'd0);
          check("ready_after_xfer", 32'(in_ready), 32'd1);
        end
        if (out_valid) begin
          check("in_ready_in_done", 32'(in_ready), 32'd0);
          if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_out_valid: got 1 expected 0 (no word pending, cycle %0d)", cyc);
          end else begin
            check("bcd", 32'(bcd), 32'(sb[0].bcd));
            check("negative", 32'(negative), 32'(sb[0].neg));
            if (!prev_ov) check("latency", 32'(cyc - sb[0].acc), 32'd18);
            if (out_ready) begin
              if (spacing_en && last_xfer >= 0) check("spacing", 32'(cyc - last_xfer), 32'd20);
              last_xfer = cyc;
              last_bcd  = sb[0].bcd;
              last_neg  = sb[0].neg;
              void'(sb.pop_front());
            end
          end
        end else begin
          check("bcd_hold", 32'(bcd), 32'(last_bcd));
          check("neg_hold", 32'(negative), 32'(last_neg));
        end
        prev_ov   = out_valid;
        prev_xfer = out_valid && out_ready;
      end
    end
  end

  // Random backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (bp_mode) out_ready = ($urandom % 4) != 0;
    end
  end

  // Watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
    $finish;
  end

  initial begin
    logic [1:0]    ops  [8];
    logic [DW-1:0] vals [8];
    int acc;
    int acc2;
    int t;
    int gap;
    logic [DW-1:0] r;

    ops[0] = 2'b00; vals[0] = 18'd510;
    ops[1] = 2'b01; vals[1] = 18'h3FF01;
    ops[2] = 2'b01; vals[2] = 18'd5;
    ops[3] = 2'b11; vals[3] = 18'h20000;
    ops[4] = 2'b10; vals[4] = 18'd65025;
    ops[5] = 2'b00; vals[5] = 18'h3FFFF;
    ops[6] = 2'b00; vals[6] = 18'd0;
    ops[7] = 2'b01; vals[7] = 18'h20000;

    rst = 1'b1; in_valid = 1'b0; operation = 2'b00; result = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_bcd", 32'(bcd), 32'd0);
    check("reset_negative", 32'(negative), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      send(ops[i], vals[i], 1'b1, 1'b0, acc);
      drain();
    end

    // Backpressure with a new word waiting at the input.
    out_ready = 1'b0;
    send(2'b00, 18'd12345, 1'b1, 1'b1, acc);
    operation = 2'b01;
    result    = 18'h3FF85;
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("bp_out_valid_seen", 32'(out_valid), 32'd1);
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    send(2'b01, 18'h3FF85, 1'b1, 1'b0, acc2);
    check("bp_accept_after_xfer", 32'(acc2 - last_xfer), 32'd2);
    drain();

    // Reset during the 9th shift cycle aborts the word.
    send(2'b00, 18'd777, 1'b0, 1'b0, acc);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_bcd", 32'(bcd), 32'd0);
    check("abort_negative", 32'(negative), 32'd0);
    repeat (25) @(posedge clk);
    #1;
    send(2'b00, 18'd42, 1'b1, 1'b0, acc);
    drain();

    // Back-to-back stream.
    out_ready  = 1'b1;
    last_xfer  = -1;
    spacing_en = 1'b1;
    send(2'b00, 18'd1, 1'b1, 1'b1, acc);
    send(2'b00, 18'd99, 1'b1, 1'b1, acc);
    send(2'b00, 18'd100000, 1'b1, 1'b0, acc);
    drain();
    spacing_en = 1'b0;

    // Randomized words with random backpressure and input gaps.
    bp_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom % 5)
        0: r = 18'd0;
        1: r = 18'h3FFFF;
        2: r = 18'h20000;
        default: r = 18'($urandom);
      endcase
      send(2'($urandom % 4), r, 1'b1, 1'($urandom % 2), acc);
      gap = $urandom % 3;
      for (int j = 0; j < gap; j++) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    drain();
    bp_mode = 1'b0;
    out_ready = 1'b1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/result_bcd_converter.md
# result_bcd_converter

Sequential binary-to-BCD converter at the output end of the calculator pipeline. It accepts one ALU result word together with the operation code that produced it. It resolves the sign of subtraction results and converts the magnitude into packed BCD digits with an iterative shift-add-3 (double-dabble) datapath. Valid/ready handshakes on both sides let it sit between the ALU pipeline register and the display/readout logic.

## Interface
- DATA_WIDTH, 18: width of the incoming result word.
- DIGITS, 6: number of BCD output digits; must satisfy 10^DIGITS > 2^DATA_WIDTH - 1.
- Clock  input  1  single clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- In_Valid  input  1  Operation/Result are valid this cycle.
- In_Ready  output  1  converter can accept a new word; high only in IDLE.
- Operation  input  2  operation code that produced Result (00 add, 01 sub, 10 mul, 11 div).
- Result  input  DATA_WIDTH  ALU result word.
- Out_Valid  output  1  BCD/Negative hold a completed conversion.
- Out_Ready  input  1  downstream accepts the conversion.
- BCD  output  4*DIGITS  packed BCD magnitude; digit 0 (units) in bits [3:0].
- Negative  output  1  result is negative (subtraction only).

## Operation
- Handshake: transfer in on an edge with In_Valid && In_Ready; transfer out on an edge with Out_Valid && Out_Ready.
- States:
  - IDLE: In_Ready=1, Out_Valid=0. On an input transfer, latch the sign and magnitude, clear the BCD scratch, clear the bit counter, and go to SHIFT.
  - SHIFT: In_Ready=0, Out_Valid=0. Each cycle, first add 3 to every scratch digit ≥ 5, then shift {scratch, magnitude} left by 1, taking the magnitude MSB into scratch bit 0. Counter increments by 1. When the counter reaches DATA_WIDTH-1, the shift on that edge is the last one: go to DONE and load BCD.
  - DONE: Out_Valid=1, In_Ready=0. BCD and Negative are stable. On an output transfer, go to IDLE.
- Sign rule:
  - Negative = (Operation == 2'b01) && Result[DATA_WIDTH-1]. When set, magnitude = two's-complement negation of Result.
  - All other operations are unsigned: Negative=0 and magnitude = Result, even if the MSB is set.
- Width rule: the scratch register is 4*DIGITS bits. No digit ever exceeds 9 after conversion, and no carry is lost for any DATA_WIDTH-bit magnitude.
- Inputs offered while not in IDLE are ignored; there is no queuing. Out_Ready outside DONE is ignored.
- BCD and Negative are registered and keep the last conversion value through IDLE/SHIFT until the next DONE load.
- Reset (any state, including mid-SHIFT):
  - next state IDLE; BCD=0, Negative=0, Out_Valid=0, counter=0, In_Ready=1.
  - An in-flight conversion is discarded and produces no Out_Valid.

## Timing
- Accept edge k (IDLE→SHIFT); shift edges k+1 … k+DATA_WIDTH. Out_Valid is first high in the cycle after edge k+DATA_WIDTH (latency DATA_WIDTH = 18 cycles).
- With Out_Ready held high, the output transfer happens at edge k+DATA_WIDTH+1, In_Ready is high again in the following cycle, and the earliest next accept is edge k+DATA_WIDTH+2. Sustained throughput is one word per DATA_WIDTH+2 = 20 cycles.
- Out_Valid stays high, with BCD/Negative unchanged, for as many cycles as Out_Ready is low.
- In_Ready is a pure decode of state. No combinational path exists from In_Valid or Out_Ready to any output.
- Reset takes priority over every handshake on the same edge.

## Test plan
- Reset, then Operation=00, Result=510: Out_Valid rises 18 cycles after accept; BCD=24'h000510, Negative=0.
- Operation=01, Result=18'h3FF01 (−255): BCD=24'h000255, Negative=1. Operation=01, Result=5: BCD=24'h000005, Negative=0. Operation=11, Result=18'h20000: BCD=24'h131072, Negative=0.
- Boundaries:
  - Operation=10, Result=65025 → BCD=24'h065025.
  - Operation=00, Result=18'h3FFFF → 24'h262143.
  - Result=0 → 24'h000000.
- Backpressure: hold Out_Ready=0 for 5 cycles after Out_Valid with In_Valid=1 and a new Result. Out_Valid, BCD and Negative stay constant, In_Ready stays 0, and the new word is not accepted until the cycle after the output transfer.
- Reset asserted for one cycle at the 9th SHIFT cycle: the next cycle shows In_Ready=1, Out_Valid=0, BCD=0, and Out_Valid never rises for the aborted word. A following conversion of 42 yields 24'h000042.
- Back-to-back stream with In_Valid and Out_Ready tied high, Results 1, 99, 100000: outputs 24'h000001, 24'h000099, 24'h100000, in order, with consecutive Out_Valid pulses exactly 20 cycles apart, each one cycle wide.
